// File: rtl/sram_2848x32_req_ctrl.sv
// Request front-end for a single-port SRAM: zero-sweeps the array after reset,
// then issues masked writes and reads, buffering read data in a 2-deep FIFO.
module sram_2848x32_req_ctrl #(
    parameter int BITS       = 2848,
    parameter int WORD_DEPTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]       req_wdata,
    input  logic [BITS-1:0]       req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [BITS-1:0]       resp_rdata,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [BITS-1:0]       sram_wmask,
    input  logic [BITS-1:0]       sram_rd
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    localparam state_t RST_STATE = INIT_EN ? S_INIT : S_RUN;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(WORD_DEPTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_inflight;
    logic [1:0]            r_count;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [BITS-1:0]       r_fifo [2];

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_occ;
    logic                  w_read_room;
    logic                  w_ready;
    logic                  w_ce;

    // Occupancy counts reads still owed: buffered plus the one on the SRAM bus.
    assign w_pop       = resp_valid & resp_ready;
    assign w_push      = r_inflight;
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight}
                       - {2'b00, w_pop};
    assign w_read_room = (w_occ < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT: begin
                if (r_init_cnt == LAST_ADDR) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Outputs stay quiet while rst_n is held low, whatever the state.
    always_comb begin
        w_ready    = 1'b0;
        w_ce       = 1'b0;
        req_ready  = 1'b0;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = req_addr;
        sram_wd    = req_wdata;
        sram_wmask = req_wmask;
        if (rst_n) begin
            case (r_state)
                S_INIT: begin
                    sram_ce    = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = r_init_cnt;
                    sram_wd    = '0;
                    sram_wmask = '1;
                end
                default: begin
                    w_ready   = req_write | w_read_room;
                    w_ce      = req_valid & w_ready;
                    req_ready = w_ready;
                    sram_ce   = w_ce;
                    sram_we   = w_ce & req_write;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= sram_ce & ~sram_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= sram_rd;
        end
    end

    assign resp_valid = (r_count != 2'd0);
    assign resp_rdata = r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_sram_2848x32_req_ctrl.sv
// Bench for sram_2848x32_req_ctrl: directed table, hand sequences and
// random traffic checked against a queue-based reference with an SRAM model.
module tb_sram_2848x32_req_ctrl;

    localparam int BITS  = 2848;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NW    = BITS / 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [AW-1:0]   req_addr;
    logic [BITS-1:0] req_wdata;
    logic [BITS-1:0] req_wmask;
    logic            resp_valid;
    logic            resp_ready;
    logic [BITS-1:0] resp_rdata;
    logic            sram_ce;
    logic            sram_we;
    logic [AW-1:0]   sram_addr;
    logic [BITS-1:0] sram_wd;
    logic [BITS-1:0] sram_wmask;
    logic [BITS-1:0] sram_rd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [BITS-1:0] data;
        int              acc;
    } resp_t;

    typedef struct {
        bit            v;
        bit            w;
        logic [AW-1:0] a;
        int            wsel;
        int            msel;
        bit            rr;
        bit            e_rdy;
        bit            e_ce;
        bit            e_we;
        bit            e_rv;
        int            rsel;
    } vec_t;

    resp_t           exp_q[$];
    logic [BITS-1:0] shadow   [DEPTH];
    logic [BITS-1:0] sram_mem [DEPTH];
    logic [BITS-1:0] pat;
    logic [BITS-1:0] lowm;
    vec_t            tab [19];
    vec_t            none;

    sram_2848x32_req_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wd    (sram_wd),
        .sram_wmask (sram_wmask),
        .sram_rd    (sram_rd)
    );

    always #5 clk = ~clk;

    // Single-port SRAM: masked write, read data registered one cycle later.
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_wmask)
                                     | (sram_wd & sram_wmask);
            end else begin
                sram_rd <= sram_mem[sram_addr];
            end
        end
    end

    function automatic logic [BITS-1:0] rbits();
        logic [BITS-1:0] r;
        for (int i = 0; i < NW; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    function automatic logic [BITS-1:0] rsel(input int s);
        case (s)
            1:       return pat;
            2:       return pat & lowm;
            default: return '0;
        endcase
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [BITS-1:0] act,
                        input logic [BITS-1:0] exp);
        int k;
        checks++;
        if (act !== exp) begin
            errors++;
            k = 0;
            for (int i = NW - 1; i >= 0; i--) begin
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) k = i;
            end
            $display("FAIL %s: word %0d got %h want %h (t=%0t)",
                     nm, k, act[k*32 +: 32], exp[k*32 +: 32], $time);
        end
    endtask

    task automatic drive(input bit v, input bit w, input int a,
                         input logic [BITS-1:0] d, input logic [BITS-1:0] m,
                         input bit rr);
        req_valid  = v;
        req_write  = w;
        req_addr   = AW'(a);
        req_wdata  = d;
        req_wmask  = m;
        resp_ready = rr;
    endtask

    // One RUN cycle: predict from outstanding reads, compare, then advance.
    task automatic tick(input bit use_tab, input vec_t t);
        int n;
        int a;
        bit ev;
        bit pop;
        bit er;
        bit acc;
        @(negedge clk);
        n  = exp_q.size();
        ev = 1'b0;
        if (n > 0) ev = (exp_q[0].acc + 2 <= cyc);
        pop = ev && resp_ready;
        er  = req_write || ((n - int'(pop)) < 2);
        acc = req_valid && er;
        a   = int'(req_addr);
        chk1("resp_valid", resp_valid, ev);
        chk1("req_ready", req_ready, er);
        chk1("sram_ce", sram_ce, acc);
        chk1("sram_we", sram_we, acc && req_write);
        if (acc) begin
            chkw("sram_addr", BITS'(sram_addr), BITS'(req_addr));
            chkw("sram_wd", sram_wd, req_wdata);
            chkw("sram_wmask", sram_wmask, req_wmask);
        end
        if (ev) chkw("resp_rdata", resp_rdata, exp_q[0].data);
        if (use_tab) begin
            chk1("tab_ready", req_ready, t.e_rdy);
            chk1("tab_ce", sram_ce, t.e_ce);
            chk1("tab_we", sram_we, t.e_we);
            chk1("tab_resp_valid", resp_valid, t.e_rv);
            if (t.e_rv) chkw("tab_rdata", resp_rdata, rsel(t.rsel));
        end
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            if (req_write) begin
                shadow[a] = (shadow[a] & ~req_wmask) | (req_wdata & req_wmask);
            end else begin
                exp_q.push_back('{data: shadow[a], acc: cyc});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Entered with rst_n low; releases it and follows the zero sweep.
    task automatic init_seq();
        @(negedge clk);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_ready", req_ready, 1'b0);
        chk1("rst_ce", sram_ce, 1'b0);
        chk1("rst_we", sram_we, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk1("init_ce", sram_ce, 1'b1);
            chk1("init_we", sram_we, 1'b1);
            chk1("init_ready", req_ready, 1'b0);
            chkw("init_addr", BITS'(sram_addr), BITS'(i));
            chkw("init_wd", sram_wd, '0);
            chkw("init_wmask", sram_wmask, '1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk1("run_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        exp_q.delete();
    endtask

    initial begin
        pat   = {NW{32'hA5A5_A5A5}};
        lowm  = {{(BITS/2){1'b0}}, {(BITS/2){1'b1}}};
        rst_n = 1'b0;
        drive(0, 0, 0, '0, '0, 0);
        repeat (2) @(posedge clk);
        #1;
        init_seq();

        //        v  w  a  ws ms rr rdy ce we rv rs
        tab[0]  = '{1, 1, 5, 1, 0, 1, 1, 1, 1, 0, 0};
        tab[1]  = '{1, 0, 5, 0, 0, 1, 1, 1, 0, 0, 0};
        tab[2]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tab[3]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
        tab[4]  = '{1, 1, 7, 1, 1, 1, 1, 1, 1, 0, 0};
        tab[5]  = '{1, 0, 7, 0, 0, 1, 1, 1, 0, 0, 0};
        tab[6]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tab[7]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2};
        tab[8]  = '{1, 0, 5, 0, 0, 0, 1, 1, 0, 0, 0};
        tab[9]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        tab[10] = '{1, 0, 7, 0, 0, 0, 0, 0, 0, 1, 1};
        tab[11] = '{1, 1, 3, 1, 0, 0, 1, 1, 1, 1, 1};
        tab[12] = '{1, 0, 7, 0, 0, 1, 1, 1, 0, 1, 1};
        tab[13] = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 1, 0};
        tab[14] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2};
        tab[15] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
        tab[16] = '{1, 0, 3, 0, 0, 1, 1, 1, 0, 0, 0};
        tab[17] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tab[18] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 19; i++) begin
            drive(tab[i].v, tab[i].w, int'(tab[i].a),
                  rsel(tab[i].wsel), tab[i].msel == 1 ? lowm : '1,
                  tab[i].rr);
            tick(1'b1, tab[i]);
        end

        // Streaming reads: no back-pressure, one response per cycle.
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, i, '0, '0, 1);
            #1;
            chk1("b2b_ready", req_ready, 1'b1);
            if (i >= 2) chk1("b2b_valid", resp_valid, 1'b1);
            tick(1'b0, none);
        end
        drive(0, 0, 0, '0, '0, 1);
        repeat (3) tick(1'b0, none);

        // Fill the FIFO, then reset asynchronously mid-cycle.
        drive(1, 0, 5, '0, '0, 0);
        tick(1'b0, none);
        drive(1, 0, 7, '0, '0, 0);
        tick(1'b0, none);
        drive(0, 0, 0, '0, '0, 0);
        repeat (2) tick(1'b0, none);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_resp_valid", resp_valid, 1'b0);
        chk1("arst_ready", req_ready, 1'b0);
        chk1("arst_ce", sram_ce, 1'b0);
        exp_q.delete();
        init_seq();
        drive(0, 0, 0, '0, '0, 1);
        repeat (4) tick(1'b0, none);

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, DEPTH - 1), rbits(),
                  $urandom_range(0, 1) == 1 ? {BITS{1'b1}} : rbits(),
                  $urandom_range(0, 3) != 0);
            tick(1'b0, none);
        end
        drive(0, 0, 0, '0, '0, 1);
        repeat (4) tick(1'b0, none);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_2848x32_req_ctrl.md
SRAM_2848X32_REQ_CTRL -- requirements
Module: sram_2848x32_req_ctrl

Interface
REQ-001 Parameter BITS, default 2848, SRAM word width.
REQ-002 Parameter WORD_DEPTH, default 32, SRAM word count.
REQ-003 Parameter ADDR_WIDTH, default 5, address width.
REQ-004 Parameter INIT_EN, default 1; 1 enables the post-reset zero sweep.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  input  1  request offered.
REQ-008 req_ready  output  1  request accepted when high with req_valid.
REQ-009 req_write  input  1  1 = masked write, 0 = read.
REQ-010 req_addr  input  ADDR_WIDTH  word address.
REQ-011 req_wdata  input  BITS  write data.
REQ-012 req_wmask  input  BITS  per-bit write enable.
REQ-013 resp_valid  output  1  read data available.
REQ-014 resp_ready  input  1  consumer takes read data.
REQ-015 resp_rdata  output  BITS  read data, FIFO head.
REQ-016 sram_ce  output  1  to SRAM ce_in.
REQ-017 sram_we  output  1  to SRAM we_in.
REQ-018 sram_addr  output  ADDR_WIDTH  to SRAM addr_in.
REQ-019 sram_wd  output  BITS  to SRAM wd_in.
REQ-020 sram_wmask  output  BITS  to SRAM w_mask_in.
REQ-021 sram_rd  input  BITS  from SRAM rd_out; valid the cycle after a read issue.

Function
REQ-022 States INIT and RUN; INIT entered on reset when INIT_EN=1, otherwise RUN.
REQ-023 INIT: sram_ce=1, sram_we=1, sram_wd=0, sram_wmask=all ones, sram_addr=init counter 0..WORD_DEPTH-1, one word per cycle; req_ready=0.
REQ-024 INIT -> RUN on the cycle after the write to address WORD_DEPTH-1; sweep lasts exactly WORD_DEPTH cycles.
REQ-025 RUN: sram_ce = req_valid & req_ready; sram_we = sram_ce & req_write; sram_addr/sram_wd/sram_wmask = req_addr/req_wdata/req_wmask, combinationally.
REQ-026 Write acceptance: req_ready=1 in RUN for writes regardless of response occupancy; writes produce no response.
REQ-027 Read acceptance: req_ready=1 in RUN iff (fifo_count + inflight - pop) < 2; pop = resp_valid & resp_ready; inflight = a read was issued in the previous cycle.
REQ-028 req_ready shall not depend on req_write being 1 or 0 except through REQ-026/REQ-027 (reads gated, writes not).
REQ-029 Read issued at cycle T: sram_rd captured into the 2-entry response FIFO at the end of T+1; resp_valid high from T+2; minimum latency 2.
REQ-030 FIFO is in-order, depth 2; simultaneous push and pop leaves count unchanged; push never occurs when full (guaranteed by REQ-027).
REQ-031 resp_valid = fifo_count != 0; resp_rdata stable while resp_valid & !resp_ready.
REQ-032 Back-to-back reads with resp_ready held 1 sustain one read per cycle.
REQ-033 Read after write to same address in consecutive cycles returns the written data (SRAM ordering); no bypass logic.

Reset
REQ-034 rst_n low asynchronously: state=INIT (or RUN if INIT_EN=0), init counter=0, fifo_count=0, inflight=0, resp_valid=0, req_ready=0, sram_ce=0, sram_we=0.
REQ-035 Reset mid-operation discards in-flight and buffered reads; no response is produced for them.
REQ-036 After rst_n rises, sweep starts on the first rising clk edge.

Verification
REQ-037 Reset release, INIT_EN=1 -> 32 cycles of sram_ce=1, sram_we=1, addr 0..31, wd=0, req_ready=0; req_ready=1 on cycle 33.
REQ-038 Write addr 5 data 0xA5 pattern mask all ones, then read addr 5 -> resp_valid 2 cycles after read accept, resp_rdata=pattern.
REQ-039 Masked write: mask low half only over pre-zeroed word -> read returns pattern in low half, zeros in high half.
REQ-040 Reads to addr 0,1,2,3 back-to-back with resp_ready=0 -> two accepted, req_ready=0 for reads, writes still accepted; raise resp_ready -> remaining reads drain, responses in order.
REQ-041 Continuous reads with resp_ready=1 -> one resp per cycle, no bubble after startup.
REQ-042 Assert rst_n low with two responses buffered -> resp_valid=0 immediately, no stale responses after re-init.
